// File: rtl/arashi_slot_alloc_if.sv
// Request/grant/release bundle between the write requesters and the slot allocator.
interface arashi_slot_alloc_if #(
  parameter int N     = 4,
  parameter int DEPTH = 32
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int OW = $clog2(DEPTH + 1);

  logic [N-1:0]    wr;
  logic [N-1:0]    gnt;
  logic [N*AW-1:0] addr;
  logic [CW-1:0]   alloc_cnt;
  logic            rel_valid;
  logic [CW-1:0]   rel_cnt;
  logic            flush;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [OW-1:0]   used;
  logic            full;
  logic            empty;
  logic            rel_err;

  modport master (
    output wr, rel_valid, rel_cnt, flush,
    input  gnt, addr, alloc_cnt, head, tail, used, full, empty, rel_err
  );

  modport slave (
    input  wr, rel_valid, rel_cnt, flush,
    output gnt, addr, alloc_cnt, head, tail, used, full, empty, rel_err
  );
endinterface

// File: rtl/arashi_slot_alloc.sv
// Circular-buffer slot allocator: packs simultaneous write requests onto
// consecutive slots from head, frees slots in order from tail.
module arashi_slot_alloc #(
  parameter int N     = 4,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  arashi_slot_alloc_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(N + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam logic [OW:0]   DEPTH_S = (OW+1)'(DEPTH);

  // base < DEPTH and inc <= DEPTH, so a single conditional subtract wraps
  // correctly for any DEPTH, power of two or not.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                             input logic [OW-1:0] inc);
    logic [OW:0] s;
    s = (OW+1)'(base) + (OW+1)'(inc);
    if (s >= DEPTH_S) s = s - DEPTH_S;
    return AW'(s);
  endfunction

  logic [AW-1:0]   head_p1;
  logic [AW-1:0]   tail_p1;
  logic [OW-1:0]   used_p1;
  logic            rel_err_p1;

  logic [OW-1:0]   free_p0;
  logic [CW-1:0]   cnt_p0;
  logic [N-1:0]    gnt_p0;
  logic [N*AW-1:0] addr_p0;
  logic [OW-1:0]   rel_eff_p0;
  logic            rel_over_p0;

  // Grant scan: lowest index first, capped by free space seen at the start of the cycle
  always_comb begin
    free_p0 = DEPTH_O - used_p1;
    cnt_p0  = '0;
    gnt_p0  = '0;
    addr_p0 = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.wr[i] && (OW'(cnt_p0) < free_p0)) begin
        gnt_p0[i]             = 1'b1;
        addr_p0[i*AW +: AW]   = wrap_add(head_p1, OW'(cnt_p0));
        cnt_p0                = cnt_p0 + CW'(1);
      end
    end
  end

  // Release clamp: never free more than is allocated; flag the attempt
  always_comb begin
    rel_eff_p0  = '0;
    rel_over_p0 = 1'b0;
    if (bus.rel_valid) begin
      if (OW'(bus.rel_cnt) > used_p1) begin
        rel_eff_p0  = used_p1;
        rel_over_p0 = 1'b1;
      end else begin
        rel_eff_p0  = OW'(bus.rel_cnt);
      end
    end
  end

  // ---- stage boundary: pointer/occupancy state ----
  // Alloc and release land in one update; flush clears pointers but keeps the sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      head_p1    <= '0;
      tail_p1    <= '0;
      used_p1    <= '0;
      rel_err_p1 <= 1'b0;
    end else if (bus.flush) begin
      head_p1    <= '0;
      tail_p1    <= '0;
      used_p1    <= '0;
    end else begin
      head_p1    <= wrap_add(head_p1, OW'(cnt_p0));
      tail_p1    <= wrap_add(tail_p1, rel_eff_p0);
      used_p1    <= used_p1 + OW'(cnt_p0) - rel_eff_p0;
      if (rel_over_p0) rel_err_p1 <= 1'b1;
    end
  end

  assign bus.gnt       = gnt_p0;
  assign bus.addr      = addr_p0;
  assign bus.alloc_cnt = cnt_p0;
  assign bus.head      = head_p1;
  assign bus.tail      = tail_p1;
  assign bus.used      = used_p1;
  assign bus.full      = (used_p1 == DEPTH_O);
  assign bus.empty     = (used_p1 == '0);
  assign bus.rel_err   = rel_err_p1;
endmodule

// File: tb/tb_arashi_slot_alloc.sv
// Randomised bench for arashi_slot_alloc against a queue-based occupancy model.
module tb_arashi_slot_alloc;
  localparam int N     = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arashi_slot_alloc_if #(.N(N), .DEPTH(DEPTH)) bus ();
  arashi_slot_alloc #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errs   = 0;
  int checks = 0;

  // Model: the allocated slots in allocation order, plus head/tail pointers.
  int slots[$];
  int m_head = 0;
  int m_tail = 0;
  bit m_err  = 1'b0;

  logic [N-1:0]    obs_gnt;
  logic [N*AW-1:0] obs_addr;
  int              obs_cnt;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational and registered outputs mid-cycle,
  // clock, then advance the model.
  task automatic step(input logic [N-1:0] w, input bit rv, input int rc,
                      input bit fl, input bit r);
    int free, k, reff, q_used;
    logic [N-1:0] eg;
    int ea[N];
    bus.wr        = w;
    bus.rel_valid = rv;
    bus.rel_cnt   = CW'(rc);
    bus.flush     = fl;
    rst           = r;
    #4;
    q_used = slots.size();
    free   = DEPTH - q_used;
    k      = 0;
    eg     = '0;
    for (int i = 0; i < N; i++) begin
      ea[i] = 0;
      if (w[i] && k < free) begin
        eg[i] = 1'b1;
        ea[i] = (m_head + k) % DEPTH;
        k++;
      end
    end
    chk("gnt", bus.gnt, eg);
    chk("alloc_cnt", bus.alloc_cnt, k);
    for (int i = 0; i < N; i++)
      chk($sformatf("addr%0d", i), bus.addr[i*AW +: AW], ea[i]);
    chk("head", bus.head, m_head);
    chk("tail", bus.tail, m_tail);
    chk("used", bus.used, q_used);
    chk("full", bus.full, q_used == DEPTH);
    chk("empty", bus.empty, q_used == 0);
    chk("rel_err", bus.rel_err, m_err);
    obs_gnt  = bus.gnt;
    obs_addr = bus.addr;
    obs_cnt  = bus.alloc_cnt;
    @(posedge clk);
    reff = rv ? ((rc > q_used) ? q_used : rc) : 0;
    if (r) begin
      slots.delete();
      m_head = 0; m_tail = 0; m_err = 1'b0;
    end else if (fl) begin
      slots.delete();
      m_head = 0; m_tail = 0;
    end else begin
      repeat (reff) void'(slots.pop_front());
      for (int i = 0; i < N; i++) if (eg[i]) slots.push_back(ea[i]);
      m_head = (m_head + k) % DEPTH;
      m_tail = (m_tail + reff) % DEPTH;
      if (rv && rc > q_used) m_err = 1'b1;
    end
    #1;
    if (slots.size() > 0) chk("tail_oldest", bus.tail, slots[0]);
  endtask

  initial begin
    int t0;
    bus.wr = '0; bus.rel_valid = 1'b0; bus.rel_cnt = '0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_head", bus.head, 0);
    chk("rst_tail", bus.tail, 0);
    chk("rst_used", bus.used, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_err", bus.rel_err, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_addr", bus.addr, 0);

    // Sparse pack from head=3, used=3
    step(4'b0111, 0, 0, 0, 0);
    step(4'b1010, 0, 0, 0, 0);
    chk("sparse_gnt", obs_gnt, 4'b1010);
    chk("sparse_a0", obs_addr[0*AW +: AW], 0);
    chk("sparse_a1", obs_addr[1*AW +: AW], 3);
    chk("sparse_a2", obs_addr[2*AW +: AW], 0);
    chk("sparse_a3", obs_addr[3*AW +: AW], 4);
    chk("sparse_cnt", obs_cnt, 2);
    chk("sparse_head", bus.head, 5);
    chk("sparse_used", bus.used, 5);

    // Move to head=tail=30, used=0, then wrap
    step(4'b0000, 1, 5, 0, 0);
    for (int j = 0; j < 6; j++) step(4'b1111, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) step(4'b0000, 1, 7, 0, 0);
    step(4'b0000, 1, 4, 0, 0);
    chk("pre_wrap_tail", bus.tail, 30);
    chk("pre_wrap_used", bus.used, 0);
    step(4'b1111, 0, 0, 0, 0);
    chk("wrap_a0", obs_addr[0*AW +: AW], 30);
    chk("wrap_a1", obs_addr[1*AW +: AW], 31);
    chk("wrap_a2", obs_addr[2*AW +: AW], 0);
    chk("wrap_a3", obs_addr[3*AW +: AW], 1);
    chk("wrap_cnt", obs_cnt, 4);
    chk("wrap_head", bus.head, 2);
    chk("wrap_used", bus.used, 4);

    // Near-full partial grant
    for (int j = 0; j < 6; j++) step(4'b1111, 0, 0, 0, 0);
    step(4'b0011, 0, 0, 0, 0);
    chk("nf_used30", bus.used, 30);
    step(4'b1111, 0, 0, 0, 0);
    chk("nf_gnt", obs_gnt, 4'b0011);
    chk("nf_cnt", obs_cnt, 2);
    chk("nf_used", bus.used, 32);
    chk("nf_full", bus.full, 1);
    step(4'b1111, 0, 0, 0, 0);
    chk("full_gnt", obs_gnt, 0);
    chk("full_cnt", obs_cnt, 0);

    // Release at full
    t0 = bus.tail;
    step(4'b0001, 1, 2, 0, 0);
    chk("relfull_gnt", obs_gnt, 0);
    chk("relfull_used", bus.used, 30);
    chk("relfull_tail", bus.tail, (t0 + 2) % DEPTH);
    step(4'b0001, 0, 0, 0, 0);
    chk("relfull_next_gnt", obs_gnt, 4'b0001);

    // Over-release then flush
    for (int j = 0; j < 4; j++) step(4'b0000, 1, 7, 0, 0);
    step(4'b0000, 1, 2, 0, 0);
    chk("or_used1", bus.used, 1);
    t0 = bus.tail;
    step(4'b0000, 1, 3, 0, 0);
    chk("or_used", bus.used, 0);
    chk("or_tail", bus.tail, (t0 + 1) % DEPTH);
    chk("or_err", bus.rel_err, 1);
    step(4'b0101, 0, 0, 1, 0);
    chk("fl_head", bus.head, 0);
    chk("fl_tail", bus.tail, 0);
    chk("fl_used", bus.used, 0);
    chk("fl_err", bus.rel_err, 1);

    // Randomised traffic with alternating fill/drain bias
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] w;
      bit rv, fl, r;
      int rc;
      bit fill;
      fill = ((cyc / 150) % 2) == 0;
      w    = N'($urandom_range(0, 15));
      rv   = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rc   = $urandom_range(0, 7);
      fl   = ($urandom_range(0, 199) == 0);
      r    = ($urandom_range(0, 499) == 0);
      step(w, rv, rc, fl, r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/arashi_slot_alloc.md
# arashi_slot_alloc

Parametrised, stateful successor to the 4-port write arbiter. It packs up to N simultaneous write requests onto consecutive slot addresses of a circular buffer with DEPTH entries. It keeps the allocation head, release tail and occupancy in registers, wraps addresses modulo DEPTH, and grants only as many requests as free slots allow (lowest index first). It sits between the write requesters and the shared slot RAM; the downstream consumer returns slots in order through the release port.

## Interface
- N, 4, number of write requesters (≥1)
- DEPTH, 32, number of slots (≥N; need not be a power of two)
- AW, $clog2(DEPTH), slot address width (derived; do not override)
- CW, $clog2(N+1), width of per-cycle counts (derived)
- OW, $clog2(DEPTH+1), width of the occupancy count (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- wr  in  N  write request, bit i = requester i
- gnt  out  N  grant, bit i = requester i received a slot this cycle
- addr  out  N*AW  slot address, requester i at [i*AW +: AW]; 0 when not granted
- alloc_cnt  out  CW  number of grants this cycle (popcount of gnt)
- rel_valid  in  1  release strobe
- rel_cnt  in  CW  slots freed from tail when rel_valid=1
- flush  in  1  synchronous clear of pointers and occupancy
- head  out  AW  next slot to allocate (registered)
- tail  out  AW  oldest allocated slot (registered)
- used  out  OW  allocated slot count (registered)
- full  out  1  used == DEPTH
- empty  out  1  used == 0
- rel_err  out  1  sticky over-release flag

## Operation
- free = DEPTH − used, using the registered value. Releases in the same cycle do not add free space until the next cycle.
- Grant selection: scan wr from bit 0 upward and grant each set bit while granted count < free. Bits above the limit get gnt=0.
- Address packing: the k-th granted requester (k=0 for lowest granted index) gets addr = (head + k) mod DEPTH. Ungranted lanes read 0.
- alloc_cnt = number of granted bits, 0..min(N, free).
- Release: rel_eff = rel_valid ? min(rel_cnt, used) : 0. If rel_valid and rel_cnt > used, set rel_err.
- Next state:
  - head ← (head + alloc_cnt) mod DEPTH
  - tail ← (tail + rel_eff) mod DEPTH
  - used ← used + alloc_cnt − rel_eff
- Invariant: used == (head − tail) mod DEPTH, except when full, where head == tail.
- flush=1: next head=tail=used=0. Grants are still computed combinationally in that cycle but are discarded. rel_err is unchanged.
- rst=1: all state cleared, including rel_err. rst has priority over flush.
- All wraps use a mod-DEPTH compare/subtract, never power-of-two truncation.

## Timing
- gnt, addr and alloc_cnt are combinational from wr, head and used: zero-cycle latency, and they must be sampled in the same cycle.
- head, tail, used, full, empty and rel_err are registered and update on the edge after the request/release.
- Reset values: head=0, tail=0, used=0, full=0, empty=1, rel_err=0. gnt, addr and alloc_cnt are 0 while wr=0.
- Full: all gnt=0 and alloc_cnt=0 whatever wr is. A release that same cycle allows grants from the next cycle.
- Simultaneous alloc and release are applied in one update.
- Mid-operation reset or flush drops all outstanding slots. Requesters must treat earlier grants as void.
- No combinational path from rel_valid or rel_cnt to gnt or addr.

## Test plan
Parameters N=4, DEPTH=32.
- **Reset:** assert rst 2 cycles, wr=0 → head=0, tail=0, used=0, empty=1, full=0, rel_err=0, gnt=0, addr=0.
- **Sparse pack:** head=3, used=3, wr=4'b1010 → gnt=1010, addr lane1=3, lane3=4, lanes0/2=0, alloc_cnt=2. Next cycle: head=5, used=5.
- **Wrap:** head=tail=30, used=0, wr=4'b1111 → addrs 30, 31, 0, 1, alloc_cnt=4. Next cycle: head=2, used=4.
- **Near-full partial grant:** used=30, wr=4'b1111 → gnt=0011, alloc_cnt=2. Next cycle: used=32, full=1. With wr=1111 held, gnt=0.
- **Simultaneous release at full:** used=32, wr=0001, rel_valid=1, rel_cnt=2 → gnt=0 this cycle. Next cycle: used=30, tail advanced by 2, and wr=0001 now granted.
- **Over-release and flush:** used=1, rel_valid=1, rel_cnt=3 → next cycle: used=0, tail+1, rel_err=1. Then flush=1 → head=tail=used=0, rel_err stays 1. Only rst clears rel_err.
